// File: rtl/imem_arbiter_pkg.sv
// Shared bus definitions for the program/data RAM arbiter.
// State encoding, requester IDs and RAM geometry.
package cpu_bus_pkg;

  localparam int ADDR_W_DFLT = 14;
  localparam int RAM_WORDS   = 1 << ADDR_W_DFLT;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IF_RD = 2'd1;
  localparam logic [1:0] S_D_RD  = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_IF,
    REQ_D,
    REQ_LD
  } req_id_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Requester-side bus of the RAM arbiter: fetch, data, loader,
// plus the stall/fault status returned to the core.
interface imem_arbiter_if #(
  parameter int ADDR_W = 14
);

  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              ld_active;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_wdata;

  logic              stall;
  logic              fault;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  ld_active, ld_we, ld_addr, ld_wdata,
    output stall, fault
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output ld_active, ld_we, ld_addr, ld_wdata,
    input  stall, fault
  );

endinterface

// File: rtl/imem_arbiter.sv
// Single-port RAM arbiter: data > fetch with a starvation
// override for fetch; the boot loader owns the RAM while active.
module imem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              sys_clk_i,
  input  logic              rst_i,
  imem_arbiter_if.slave     bus,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_fault_q, rd_fault_d;

  logic          run;
  logic          ld_own;
  logic          starve_hit;
  logic          if_gnt;
  logic          d_gnt;
  logic [31:0]   sel_addr;
  logic          oor;
  req_id_e       owner;
  logic          unused_addr_lo;

  // Outputs are held quiet while reset is asserted.
  assign run        = !rst_i;
  assign ld_own     = run & (bus.ld_active | (state_q == S_LOAD));
  assign starve_hit = (starve_q == SW'(STARVE_LIMIT));

  assign if_gnt = run & !ld_own & bus.if_req
                & (starve_hit | !bus.d_req);
  assign d_gnt  = run & !ld_own & bus.d_req & !if_gnt;

  // Pick the single owner of the RAM this cycle.
  always_comb begin
    owner = REQ_NONE;
    unique case (1'b1)
      ld_own:  owner = REQ_LD;
      if_gnt:  owner = REQ_IF;
      d_gnt:   owner = REQ_D;
      default: owner = REQ_NONE;
    endcase
  end

  assign sel_addr       = (owner == REQ_D) ? bus.d_addr
                                           : bus.if_addr;
  assign oor            = |sel_addr[31:ADDR_W+2];
  assign unused_addr_lo = ^sel_addr[1:0];

  // Drive the RAM port from the current owner; out-of-range
  // accesses are granted but never reach the macro.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (owner)
      REQ_LD: begin
        mem_en_o    = bus.ld_we;
        mem_we_o    = {4{bus.ld_we}};
        mem_addr_o  = bus.ld_addr;
        mem_wdata_o = bus.ld_wdata;
      end
      REQ_IF: begin
        mem_en_o   = !oor;
        mem_addr_o = sel_addr[ADDR_W+1:2];
      end
      REQ_D: begin
        mem_en_o    = !oor;
        mem_we_o    = (bus.d_we & !oor) ? bus.d_be : 4'h0;
        mem_addr_o  = sel_addr[ADDR_W+1:2];
        mem_wdata_o = bus.d_wdata;
      end
      default: ;
    endcase
  end

  // Track who owns the read in flight and loader ownership.
  always_comb begin
    state_d    = S_IDLE;
    rd_fault_d = 1'b0;
    if (bus.ld_active) begin
      state_d = S_LOAD;
    end else if (state_q == S_LOAD) begin
      state_d = S_IDLE;
    end else if (if_gnt) begin
      state_d    = S_IF_RD;
      rd_fault_d = oor;
    end else if (d_gnt & !bus.d_we) begin
      state_d    = S_D_RD;
      rd_fault_d = oor;
    end
  end

  // Count lost fetch arbitrations, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = '0;
    end else if (bus.if_req & !starve_hit) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // State registers.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      rd_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rd_fault_q <= rd_fault_d;
    end
  end

  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;
  assign bus.fault  = (if_gnt | d_gnt) & oor;

  assign bus.if_rvalid = run & (state_q == S_IF_RD);
  assign bus.d_rvalid  = run & (state_q == S_D_RD);

  assign bus.if_rdata = (bus.if_rvalid & !rd_fault_q)
                      ? mem_rdata_i : 32'h0;
  assign bus.d_rdata  = (bus.d_rvalid & !rd_fault_q)
                      ? mem_rdata_i : 32'h0;

  assign bus.stall = run & ((bus.if_req & !if_gnt)
                          | (bus.d_req & !d_gnt)
                          | (state_q == S_LOAD)
                          | bus.ld_active);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural RAM and a
// read-data scoreboard checked by an independent monitor.
module tb_imem_arbiter;
  import cpu_bus_pkg::*;

  localparam int AW = 14;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0]   ram [RAM_WORDS];

  int   checks;
  int   errors;
  int   cyc;
  bit   no_push;
  exp_t ifq [$];
  exp_t dq  [$];

  imem_arbiter_if #(.ADDR_W(AW)) bus ();

  imem_arbiter #(
    .ADDR_W(AW),
    .STARVE_LIMIT(4)
  ) dut (
    .sys_clk_i  (clk),
    .rst_i      (rst),
    .bus        (bus),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rinit(int i);
    return (i < 128) ? (32'h1000_0000 + 32'(i)) : 32'h0;
  endfunction

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) ram[i] = rinit(i);
  end

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.if_rvalid) begin
      if (ifq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL if_rvalid: pulse at cycle %0d, none required", cyc);
      end else begin
        e = ifq.pop_front();
        chk("if_rdata", bus.if_rdata, e.data);
        chk("if_rvalid_cycle", cyc, e.cyc);
      end
    end
    if (bus.d_rvalid) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d_rvalid: pulse at cycle %0d, none required", cyc);
      end else begin
        e = dq.pop_front();
        chk("d_rdata", bus.d_rdata, e.data);
        chk("d_rvalid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input string tag,
                        input bit eig, edg, est, eft,
                        input logic [31:0] eid, edd);
    @(negedge clk);
    chk({tag, ".if_gnt"}, bus.if_gnt, eig);
    chk({tag, ".d_gnt"},  bus.d_gnt,  edg);
    chk({tag, ".stall"},  bus.stall,  est);
    chk({tag, ".fault"},  bus.fault,  eft);
    if (eig && !no_push) ifq.push_back('{eid, cyc + 1});
    if (edg && !bus.d_we) dq.push_back('{edd, cyc + 1});
    no_push = 1'b0;
  endtask

  task automatic step(input string tag,
                      input bit eig, edg, est, eft,
                      input logic [31:0] eid, edd);
    sample(tag, eig, edg, est, eft, eid, edd);
    adv();
  endtask

  task automatic set_if(input bit r, input logic [31:0] a);
    bus.if_req  = r;
    bus.if_addr = a;
  endtask

  task automatic set_d(input bit r, input bit we,
                       input logic [3:0] be,
                       input logic [31:0] a, wd);
    bus.d_req   = r;
    bus.d_we    = we;
    bus.d_be    = be;
    bus.d_addr  = a;
    bus.d_wdata = wd;
  endtask

  task automatic set_ld(input bit act, we,
                        input logic [AW-1:0] a,
                        input logic [31:0] wd);
    bus.ld_active = act;
    bus.ld_we     = we;
    bus.ld_addr   = a;
    bus.ld_wdata  = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    no_push = 1'b0;
    rst     = 1'b1;
    set_if(0, 0);
    set_d(0, 0, 0, 0, 0);
    set_ld(0, 0, 0, 0);
    adv();
    adv();

    sample("reset", 0, 0, 0, 0, 0, 0);
    chk("reset.mem_en",   mem_en, 0);
    chk("reset.mem_we",   mem_we, 0);
    chk("reset.if_rdata", bus.if_rdata, 0);
    chk("reset.d_rdata",  bus.d_rdata, 0);
    adv();
    rst = 1'b0;

    set_if(1, 32'h0);
    step("fetch0", 1, 0, 0, 0, rinit(0), 0);
    set_if(1, 32'h4);
    step("fetch1", 1, 0, 0, 0, rinit(1), 0);
    set_if(1, 32'h8);
    step("fetch2", 1, 0, 0, 0, rinit(2), 0);
    set_if(0, 0);
    step("fetch_idle", 0, 0, 0, 0, 0, 0);

    set_if(1, 32'hC);
    set_d(1, 0, 0, 32'h100, 0);
    step("cont_d", 0, 1, 1, 0, 0, rinit(64));
    set_d(0, 0, 0, 0, 0);
    step("cont_if", 1, 0, 0, 0, rinit(3), 0);
    set_if(0, 0);
    step("cont_idle", 0, 0, 0, 0, 0, 0);

    set_if(1, 32'h10);
    set_d(1, 0, 0, 32'h104, 0);
    for (int i = 0; i < 4; i++)
      step($sformatf("starve_d%0d", i), 0, 1, 1, 0, 0, rinit(65));
    step("starve_if", 1, 0, 1, 0, rinit(4), 0);
    set_if(0, 0);
    step("starve_resume", 0, 1, 0, 0, 0, rinit(65));
    set_d(0, 0, 0, 0, 0);
    step("starve_idle", 0, 0, 0, 0, 0, 0);

    set_d(1, 1, 4'b0011, 32'h200, 32'hAABB_CCDD);
    sample("wr", 0, 1, 0, 0, 0, 0);
    chk("wr.mem_en",   mem_en, 1);
    chk("wr.mem_we",   mem_we, 4'b0011);
    chk("wr.mem_addr", mem_addr, 128);
    adv();
    set_d(1, 0, 0, 32'h200, 0);
    step("wr_rd", 0, 1, 0, 0, 0, 32'h0000_CCDD);
    set_d(0, 0, 0, 0, 0);
    step("wr_idle", 0, 0, 0, 0, 0, 0);

    set_d(1, 0, 0, 32'h0010_0000, 0);
    sample("fault", 0, 1, 0, 1, 0, 32'h0);
    chk("fault.mem_en", mem_en, 0);
    adv();
    set_d(0, 0, 0, 0, 0);
    step("fault_idle", 0, 0, 0, 0, 0, 0);

    set_if(1, 32'h14);
    step("ld_pre", 1, 0, 0, 0, rinit(5), 0);
    set_if(1, 32'h18);
    set_ld(1, 0, 0, 0);
    step("ld_start", 0, 0, 1, 0, 0, 0);
    set_ld(1, 1, 14'd3, 32'h1234_5678);
    sample("ld_wr", 0, 0, 1, 0, 0, 0);
    chk("ld_wr.mem_we",    mem_we, 4'hF);
    chk("ld_wr.mem_addr",  mem_addr, 3);
    chk("ld_wr.mem_wdata", mem_wdata, 32'h1234_5678);
    adv();
    set_ld(0, 0, 0, 0);
    step("ld_tail", 0, 0, 1, 0, 0, 0);
    step("ld_exit", 1, 0, 0, 0, rinit(6), 0);
    set_if(1, 32'hC);
    step("ld_readback", 1, 0, 0, 0, 32'h1234_5678, 0);
    set_if(0, 0);
    step("ld_idle", 0, 0, 0, 0, 0, 0);

    set_if(1, 32'h0);
    no_push = 1'b1;
    step("rst_rd", 1, 0, 0, 0, 0, 0);
    set_if(0, 0);
    rst = 1'b1;
    step("rst_drop", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step("rst_after", 0, 0, 0, 0, 0, 0);

    adv();
    adv();
    chk("ifq_drained", ifq.size(), 0);
    chk("dq_drained",  dq.size(),  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
